enemy_fleet_manager: RTL and testbench
======================================

// Module: enemy_fleet_manager
// PURPOSE
//  Parametrised manager for NUM_ENEMIES enemy slots. Each slot has position, direction,
//  hit count and a life-cycle FSM (alive/exploding/respawn), and the block arbitrates
//  per-pixel body and heads-up/heads-down zone requests towards the draw mux. Sits between
//  the VGA pixel counter and the object mux; the shot/collision logic feeds it.
// PARAMETERS
//  NUM_ENEMIES        4    number of slots (1..16)
//  ENEMY_WIDTH        20   body width, pixels
//  ENEMY_HEIGHT       20   body height, pixels
//  HEADS_UP_HEIGHT    80   height of warning zone above the body
//  HEADS_DOWN_HEIGHT  80   height of warning zone below the body
//  HEADS_SIDE_MARGIN  8    side margin of heads-up zone (heads-down uses margin+3)
//  X_STEP             2    horizontal pixels moved per frame
//  SCREEN_RIGHT       639  rightmost legal pixel column (left edge is 0)
//  HITS_TO_KILL       3    hits needed to destroy a slot
//  EXPLODE_FRAMES     16   frames spent in EXPLODE
//  RESPAWN_FRAMES     120  frames spent in RESPAWN before re-entering ALIVE
// PORTS  (ID_W = max(1,$clog2(NUM_ENEMIES)))
//  clk                in   1     system clock
//  reset              in   1     synchronous, active-high reset
//  startOfFrame       in   1     one-cycle pulse per frame
//  pixelX, pixelY     in   11    current VGA pixel
//  shotCollision      in   1     shot overlaps a drawn enemy body this cycle
//  changeDir          in   1     enemy touched an obstacle this cycle
//  pause              in   1     freeze motion, timers and hit application
//  spawnEnable        in   1     allow RESPAWN -> ALIVE
//  enemyDrawReq       out  1     body (ALIVE or EXPLODE slot) covers pixel
//  explodingDrawReq   out  1     winning body slot is in EXPLODE
//  headsUpDrawReq     out  1     heads-up zone of an ALIVE slot covers pixel
//  headsDownDrawReq   out  1     heads-down zone of an ALIVE slot covers pixel
//  drawingRequestorId out  ID_W  slot that won arbitration
//  offsetX, offsetY   out  11    pixel minus winning body top-left; 0 with no body request
//  killPulse          out  1     one cycle: at least one slot entered EXPLODE
//  aliveCount         out  ID_W+1 registered number of ALIVE slots
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: slot i -> ALIVE, TLX=100*(i+1), TLY=60*(i+1), dir=right, hits=0, timers/pending=0;
//   killPulse=0, aliveCount=NUM_ENEMIES on the first cycle after reset. Reset mid-frame
//   discards all pending events. Draw outputs are combinational.
//  Slot FSM, advances only on startOfFrame && !pause:
//   ALIVE -> EXPLODE when pending hit makes hits==HITS_TO_KILL; timer=EXPLODE_FRAMES-1.
//   EXPLODE -> RESPAWN when timer==0 (decrement per frame); timer=RESPAWN_FRAMES-1.
//   RESPAWN -> ALIVE when timer==0 && spawnEnable (else hold at 0); hits=0, initial pos/dir.
//  Motion (ALIVE, startOfFrame, !pause): x+=/-X_STEP; result <0 clamps to 0, and
//   x+ENEMY_WIDTH-1 > SCREEN_RIGHT clamps to SCREEN_RIGHT-ENEMY_WIDTH+1; either flips dir.
//   Signed 12-bit intermediate; Y is never changed.
//  Events: changeDir while any draw request is asserted sets pending_flip[drawingRequestorId];
//   shotCollision while enemyDrawReq with a winning ALIVE slot sets pending_hit[id]. Pending bits
//   are applied and cleared on the next unpaused startOfFrame, so each is at most once per
//   slot per frame. Hits saturate at HITS_TO_KILL. Flip is applied before the motion step.
//   Events arriving in the startOfFrame cycle itself count for the next frame.
//  Zones: body X in [TLX,TLX+W-1], Y in [TLY,TLY+H-1]. Heads-up: X +/- HEADS_SIDE_MARGIN,
//   Y in [TLY-HEADS_UP_HEIGHT,TLY-1], lower bound clipped at 0 (no unsigned wrap).
//   Heads-down: X +/- (HEADS_SIDE_MARGIN+3), Y in [TLY+H, TLY+H+HEADS_DOWN_HEIGHT-1].
//  Arbitration: body beats heads-up beats heads-down; within a class the lowest index wins;
//   drawingRequestorId follows the winner of the highest active class, else 0.
//  killPulse: registered, high the cycle after startOfFrame that moved any slot to EXPLODE.
// STRUCTURE
//  enemy_pkg: slot_state_t enum {ALIVE,EXPLODE,RESPAWN}, ID_W function, initial-position helpers.
//  Sub-module enemy_slot: one slot's FSM, timer, position, pending bits and zone hit tests;
//   generate NUM_ENEMIES instances; arbiter, aliveCount and killPulse stay in the top.
// TESTING (NUM_ENEMIES=2, defaults otherwise)
//  Reset, scan pixel (100,60) -> enemyDrawReq=1, id=0, offset=(0,0); (100,59) -> headsUp=1.
//  Slot 1 at TLX=620 moving right, one frame -> TLX=620 clamps, dir flips; next frame TLX=618.
//  3 shotCollision on slot 0 in distinct frames -> killPulse once, EXPLODE, aliveCount=1.
//  5 shotCollision on slot 0 in one frame -> hits=1 only; pause=1 across SOF -> hit stays pending.
//  Overlapping bodies at a pixel -> id=0; heads-up of 0 vs body of 1 -> enemyDrawReq, id=1.
//  EXPLODE 16 + RESPAWN 120 frames, spawnEnable=0 -> hold; raise it -> ALIVE at (100,60), hits=0.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared types and helpers for the enemy fleet: slot life-cycle states,
// id-width sizing and the reset/respawn placement of each slot.
package enemy_pkg;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    EXPLODE = 2'd1,
    RESPAWN = 2'd2
  } slot_state_t;

  localparam int unsigned COORD_W = 11;

  function automatic int unsigned idWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Slots start staggered diagonally so they never share a row band.
  function automatic logic [COORD_W-1:0] initTlx(input int unsigned idx);
    return COORD_W'(100 * (idx + 1));
  endfunction

  function automatic logic [COORD_W-1:0] initTly(input int unsigned idx);
    return COORD_W'(60 * (idx + 1));
  endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: life-cycle FSM, frame timer, horizontal motion, pending
// hit/flip events and the per-pixel body / heads-up / heads-down hit tests.
module enemy_slot
  import enemy_pkg::*;
#(
  parameter int unsigned SLOT_INDEX        = 0,
  parameter int unsigned ENEMY_WIDTH       = 20,
  parameter int unsigned ENEMY_HEIGHT      = 20,
  parameter int unsigned HEADS_UP_HEIGHT   = 80,
  parameter int unsigned HEADS_DOWN_HEIGHT = 80,
  parameter int unsigned HEADS_SIDE_MARGIN = 8,
  parameter int unsigned X_STEP            = 2,
  parameter int unsigned SCREEN_RIGHT      = 639,
  parameter int unsigned HITS_TO_KILL      = 3,
  parameter int unsigned EXPLODE_FRAMES    = 16,
  parameter int unsigned RESPAWN_FRAMES    = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic               spawnEnable,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               setFlip,
  input  logic               setHit,
  output slot_state_t        state,
  output logic [COORD_W-1:0] tlx,
  output logic [COORD_W-1:0] tly,
  output logic               bodyHit_c,
  output logic               headsUpHit_c,
  output logic               headsDownHit_c,
  output logic               killNow_c
);

  localparam int unsigned HIT_W      = $clog2(HITS_TO_KILL + 1);
  localparam int unsigned MAX_FRAMES = (EXPLODE_FRAMES > RESPAWN_FRAMES) ? EXPLODE_FRAMES
                                                                         : RESPAWN_FRAMES;
  localparam int unsigned TIMER_W    = $clog2(MAX_FRAMES + 1);
  localparam int unsigned EXT_W      = COORD_W + 1;
  localparam int unsigned HD_MARGIN  = HEADS_SIDE_MARGIN + 3;

  localparam logic [COORD_W-1:0]      INIT_TLX = initTlx(SLOT_INDEX);
  localparam logic [COORD_W-1:0]      INIT_TLY = initTly(SLOT_INDEX);
  localparam logic signed [EXT_W-1:0] X_MAX    = EXT_W'(SCREEN_RIGHT - ENEMY_WIDTH + 1);
  localparam logic signed [EXT_W-1:0] DX       = EXT_W'(X_STEP);

  slot_state_t               stateNext;
  logic [COORD_W-1:0]        tlxNext;
  logic                      dir;
  logic                      dirNext;
  logic [HIT_W-1:0]          hits;
  logic [HIT_W-1:0]          hitsNext;
  logic [HIT_W-1:0]          hitsInc;
  logic [TIMER_W-1:0]        timer;
  logic [TIMER_W-1:0]        timerNext;
  logic                      pendingFlip;
  logic                      pendingFlipNext;
  logic                      pendingHit;
  logic                      pendingHitNext;
  logic                      effDir;
  logic signed [EXT_W-1:0]   stepX;
  logic                      frameTick;

  assign frameTick = startOfFrame && !pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALIVE;
      tlx         <= INIT_TLX;
      tly         <= INIT_TLY;
      dir         <= 1'b1;
      hits        <= '0;
      timer       <= '0;
      pendingFlip <= 1'b0;
      pendingHit  <= 1'b0;
    end else begin
      state       <= stateNext;
      tlx         <= tlxNext;
      dir         <= dirNext;
      hits        <= hitsNext;
      timer       <= timerNext;
      pendingFlip <= pendingFlipNext;
      pendingHit  <= pendingHitNext;
    end
  end

  always_comb begin
    stateNext       = state;
    tlxNext         = tlx;
    dirNext         = dir;
    hitsNext        = hits;
    timerNext       = timer;
    pendingFlipNext = pendingFlip | setFlip;
    pendingHitNext  = pendingHit | setHit;
    killNow_c       = 1'b0;
    effDir          = dir ^ pendingFlip;
    hitsInc         = (hits == HIT_W'(HITS_TO_KILL)) ? hits : hits + HIT_W'(1);
    stepX           = effDir ? ($signed({1'b0, tlx}) + DX) : ($signed({1'b0, tlx}) - DX);

    // Events seen in the frame-tick cycle itself belong to the next frame.
    if (frameTick) begin
      pendingFlipNext = setFlip;
      pendingHitNext  = setHit;
      unique case (state)
        ALIVE: begin
          if (pendingHit) begin
            hitsNext = hitsInc;
            if (hitsInc == HIT_W'(HITS_TO_KILL)) begin
              stateNext = EXPLODE;
              timerNext = TIMER_W'(EXPLODE_FRAMES - 1);
              killNow_c = 1'b1;
            end
          end
          if (stepX < $signed(EXT_W'(0))) begin
            tlxNext = '0;
            dirNext = !effDir;
          end else if (stepX > X_MAX) begin
            tlxNext = X_MAX[COORD_W-1:0];
            dirNext = !effDir;
          end else begin
            tlxNext = stepX[COORD_W-1:0];
            dirNext = effDir;
          end
        end
        EXPLODE: begin
          if (timer == '0) begin
            stateNext = RESPAWN;
            timerNext = TIMER_W'(RESPAWN_FRAMES - 1);
          end else begin
            timerNext = timer - TIMER_W'(1);
          end
        end
        RESPAWN: begin
          if (timer != '0) begin
            timerNext = timer - TIMER_W'(1);
          end else if (spawnEnable) begin
            stateNext = ALIVE;
            hitsNext  = '0;
            tlxNext   = INIT_TLX;
            dirNext   = 1'b1;
          end
        end
        default: stateNext = ALIVE;
      endcase
    end
  end

  // Zone tests run one bit wider so the heads-up lower bound clips at 0.
  logic [EXT_W-1:0] px, py, x, y;
  logic inBody, inHeadsUp, inHeadsDown;

  assign px = {1'b0, pixelX};
  assign py = {1'b0, pixelY};
  assign x  = {1'b0, tlx};
  assign y  = {1'b0, tly};

  assign inBody = (px >= x) && (px <= x + EXT_W'(ENEMY_WIDTH - 1)) &&
                  (py >= y) && (py <= y + EXT_W'(ENEMY_HEIGHT - 1));
  assign inHeadsUp = (px + EXT_W'(HEADS_SIDE_MARGIN) >= x) &&
                     (px <= x + EXT_W'(ENEMY_WIDTH - 1 + HEADS_SIDE_MARGIN)) &&
                     (py < y) && (py + EXT_W'(HEADS_UP_HEIGHT) >= y);
  assign inHeadsDown = (px + EXT_W'(HD_MARGIN) >= x) &&
                       (px <= x + EXT_W'(ENEMY_WIDTH - 1 + HD_MARGIN)) &&
                       (py >= y + EXT_W'(ENEMY_HEIGHT)) &&
                       (py <= y + EXT_W'(ENEMY_HEIGHT + HEADS_DOWN_HEIGHT - 1));

  assign bodyHit_c      = (state != RESPAWN) && inBody;
  assign headsUpHit_c   = (state == ALIVE) && inHeadsUp;
  assign headsDownHit_c = (state == ALIVE) && inHeadsDown;

endmodule

// File: rtl/enemy_fleet_manager.sv
// Enemy fleet: NUM_ENEMIES slots plus the body > heads-up > heads-down
// draw arbiter, event routing back to slots, kill pulse and alive count.
module enemy_fleet_manager
  import enemy_pkg::*;
#(
  parameter int unsigned NUM_ENEMIES       = 4,
  parameter int unsigned ENEMY_WIDTH       = 20,
  parameter int unsigned ENEMY_HEIGHT      = 20,
  parameter int unsigned HEADS_UP_HEIGHT   = 80,
  parameter int unsigned HEADS_DOWN_HEIGHT = 80,
  parameter int unsigned HEADS_SIDE_MARGIN = 8,
  parameter int unsigned X_STEP            = 2,
  parameter int unsigned SCREEN_RIGHT      = 639,
  parameter int unsigned HITS_TO_KILL      = 3,
  parameter int unsigned EXPLODE_FRAMES    = 16,
  parameter int unsigned RESPAWN_FRAMES    = 120,
  localparam int unsigned ID_W             = idWidth(NUM_ENEMIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               shotCollision,
  input  logic               changeDir,
  input  logic               pause,
  input  logic               spawnEnable,
  output logic               enemyDrawReq,
  output logic               explodingDrawReq,
  output logic               headsUpDrawReq,
  output logic               headsDownDrawReq,
  output logic [ID_W-1:0]    drawingRequestorId,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               killPulse,
  output logic [ID_W:0]      aliveCount
);

  slot_state_t              slotState [NUM_ENEMIES];
  logic [COORD_W-1:0]       slotTlx   [NUM_ENEMIES];
  logic [COORD_W-1:0]       slotTly   [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0]   bodyVec, huVec, hdVec, killVec, flipVec, hitVec;
  logic                     bodyFound, huFound, hdFound;
  logic [ID_W-1:0]          bodyId, huId, hdId;
  logic [ID_W:0]            aliveNow;

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : gSlot
    enemy_slot #(
      .SLOT_INDEX        (g),
      .ENEMY_WIDTH       (ENEMY_WIDTH),
      .ENEMY_HEIGHT      (ENEMY_HEIGHT),
      .HEADS_UP_HEIGHT   (HEADS_UP_HEIGHT),
      .HEADS_DOWN_HEIGHT (HEADS_DOWN_HEIGHT),
      .HEADS_SIDE_MARGIN (HEADS_SIDE_MARGIN),
      .X_STEP            (X_STEP),
      .SCREEN_RIGHT      (SCREEN_RIGHT),
      .HITS_TO_KILL      (HITS_TO_KILL),
      .EXPLODE_FRAMES    (EXPLODE_FRAMES),
      .RESPAWN_FRAMES    (RESPAWN_FRAMES)
    ) uSlot (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .pause          (pause),
      .spawnEnable    (spawnEnable),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .setFlip        (flipVec[g]),
      .setHit         (hitVec[g]),
      .state          (slotState[g]),
      .tlx            (slotTlx[g]),
      .tly            (slotTly[g]),
      .bodyHit_c      (bodyVec[g]),
      .headsUpHit_c   (huVec[g]),
      .headsDownHit_c (hdVec[g]),
      .killNow_c      (killVec[g])
    );
  end

  // Descending scan: the last match written is the lowest index.
  always_comb begin
    bodyFound = 1'b0;
    huFound   = 1'b0;
    hdFound   = 1'b0;
    bodyId    = '0;
    huId      = '0;
    hdId      = '0;
    for (int i = int'(NUM_ENEMIES) - 1; i >= 0; i--) begin
      if (bodyVec[i]) begin
        bodyFound = 1'b1;
        bodyId    = ID_W'(i);
      end
      if (huVec[i]) begin
        huFound = 1'b1;
        huId    = ID_W'(i);
      end
      if (hdVec[i]) begin
        hdFound = 1'b1;
        hdId    = ID_W'(i);
      end
    end

    drawingRequestorId = bodyFound ? bodyId : huFound ? huId : hdFound ? hdId : '0;
    enemyDrawReq       = bodyFound;
    headsUpDrawReq     = huFound;
    headsDownDrawReq   = hdFound;
    explodingDrawReq   = bodyFound && (slotState[bodyId] == EXPLODE);
    offsetX            = bodyFound ? pixelX - slotTlx[bodyId] : '0;
    offsetY            = bodyFound ? pixelY - slotTly[bodyId] : '0;

    flipVec = '0;
    hitVec  = '0;
    if (changeDir && (bodyFound || huFound || hdFound)) begin
      flipVec[drawingRequestorId] = 1'b1;
    end
    if (shotCollision && bodyFound && (slotState[bodyId] == ALIVE)) begin
      hitVec[bodyId] = 1'b1;
    end

    aliveNow = '0;
    for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
      aliveNow = aliveNow + (ID_W + 1)'(slotState[i] == ALIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      killPulse  <= 1'b0;
      aliveCount <= (ID_W + 1)'(NUM_ENEMIES);
    end else begin
      killPulse  <= |killVec;
      aliveCount <= aliveNow;
    end
  end

endmodule

// File: tb/tb_enemy_fleet_manager.sv
// Bench for enemy_fleet_manager with two slots: a frame-level behavioural
// model checked every cycle, plus hand-computed pixel/position expectations.
module tb_enemy_fleet_manager;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, shotCollision, changeDir, pause, spawnEnable;
  logic [10:0] pixelX, pixelY;
  logic        enemyDrawReq, explodingDrawReq, headsUpDrawReq, headsDownDrawReq;
  logic [0:0]  drawingRequestorId;
  logic [10:0] offsetX, offsetY;
  logic        killPulse;
  logic [1:0]  aliveCount;

  enemy_fleet_manager #(.NUM_ENEMIES(N)) dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (startOfFrame),
    .pixelX             (pixelX),
    .pixelY             (pixelY),
    .shotCollision      (shotCollision),
    .changeDir          (changeDir),
    .pause              (pause),
    .spawnEnable        (spawnEnable),
    .enemyDrawReq       (enemyDrawReq),
    .explodingDrawReq   (explodingDrawReq),
    .headsUpDrawReq     (headsUpDrawReq),
    .headsDownDrawReq   (headsDownDrawReq),
    .drawingRequestorId (drawingRequestorId),
    .offsetX            (offsetX),
    .offsetY            (offsetY),
    .killPulse          (killPulse),
    .aliveCount         (aliveCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int killSeen = 0;
  bit en = 1'b0;

  // Model: state 0=alive 1=exploding 2=respawning; dir 1=right.
  int mX[N], mY[N], mDir[N], mHits[N], mTimer[N], mSt[N];
  bit mPH[N], mPF[N];
  int mKill, mAliveCnt;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void winners(input int px, input int py,
                                  output int b, output int u, output int d);
    b = -1; u = -1; d = -1;
    for (int i = 0; i < N; i++) begin
      if (b < 0 && mSt[i] != 2 && px >= mX[i] && px < mX[i] + 20 &&
          py >= mY[i] && py < mY[i] + 20) b = i;
      if (u < 0 && mSt[i] == 0 && px >= mX[i] - 8 && px < mX[i] + 28 &&
          py >= mY[i] - 80 && py < mY[i]) u = i;
      if (d < 0 && mSt[i] == 0 && px >= mX[i] - 11 && px < mX[i] + 31 &&
          py >= mY[i] + 20 && py < mY[i] + 100) d = i;
    end
  endfunction

  always @(posedge clk) begin
    int b, u, d, id, dr, nx, alive;
    bit [N-1:0] eH, eF;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mSt[i] = 0; mX[i] = 100 * (i + 1); mY[i] = 60 * (i + 1); mDir[i] = 1;
        mHits[i] = 0; mTimer[i] = 0; mPH[i] = 1'b0; mPF[i] = 1'b0;
      end
      mKill = 0;
      mAliveCnt = N;
    end else begin
      winners(int'(pixelX), int'(pixelY), b, u, d);
      id = (b >= 0) ? b : (u >= 0) ? u : (d >= 0) ? d : 0;
      eH = '0; eF = '0;
      if (changeDir && (b >= 0 || u >= 0 || d >= 0)) eF[id] = 1'b1;
      if (shotCollision && b >= 0 && mSt[b] == 0) eH[b] = 1'b1;
      alive = 0;
      for (int i = 0; i < N; i++) if (mSt[i] == 0) alive++;
      mAliveCnt = alive;
      mKill = 0;
      if (startOfFrame && !pause) begin
        for (int i = 0; i < N; i++) begin
          if (mSt[i] == 0) begin
            dr = mPF[i] ? 1 - mDir[i] : mDir[i];
            if (mPH[i] && mHits[i] < 3) begin
              mHits[i]++;
              if (mHits[i] == 3) begin mSt[i] = 1; mTimer[i] = 15; mKill = 1; end
            end
            nx = mX[i] + (dr == 1 ? 2 : -2);
            if (nx < 0) begin mX[i] = 0; mDir[i] = 1 - dr; end
            else if (nx + 19 > 639) begin mX[i] = 620; mDir[i] = 1 - dr; end
            else begin mX[i] = nx; mDir[i] = dr; end
          end else if (mSt[i] == 1) begin
            if (mTimer[i] == 0) begin mSt[i] = 2; mTimer[i] = 119; end
            else mTimer[i]--;
          end else begin
            if (mTimer[i] != 0) mTimer[i]--;
            else if (spawnEnable) begin
              mSt[i] = 0; mHits[i] = 0; mX[i] = 100 * (i + 1); mDir[i] = 1;
            end
          end
          mPH[i] = eH[i];
          mPF[i] = eF[i];
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          mPH[i] = mPH[i] | eH[i];
          mPF[i] = mPF[i] | eF[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    int b, u, d, id;
    if (killPulse === 1'b1) killSeen++;
    if (en) begin
      winners(int'(pixelX), int'(pixelY), b, u, d);
      id = (b >= 0) ? b : (u >= 0) ? u : (d >= 0) ? d : 0;
      chk("enemyDrawReq", int'(enemyDrawReq), (b >= 0) ? 1 : 0);
      chk("explodingDrawReq", int'(explodingDrawReq), (b >= 0 && mSt[b] == 1) ? 1 : 0);
      chk("headsUpDrawReq", int'(headsUpDrawReq), (u >= 0) ? 1 : 0);
      chk("headsDownDrawReq", int'(headsDownDrawReq), (d >= 0) ? 1 : 0);
      chk("drawingRequestorId", int'(drawingRequestorId), id);
      chk("offsetX", int'(offsetX), (b >= 0) ? int'(pixelX) - mX[b] : 0);
      chk("offsetY", int'(offsetY), (b >= 0) ? int'(pixelY) - mY[b] : 0);
      chk("killPulse", int'(killPulse), mKill);
      chk("aliveCount", int'(aliveCount), mAliveCnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic look(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(negedge clk);
    #1;
  endtask

  task automatic shoot(input int n);
    pixelX = 11'(mX[0] + 5);
    pixelY = 11'd65;
    for (int k = 0; k < n; k++) begin
      shotCollision = 1'b1;
      tick();
      shotCollision = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; shotCollision = 1'b0; changeDir = 1'b0;
    pause = 1'b0; spawnEnable = 1'b0; pixelX = '0; pixelY = '0;
    tick();
    en = 1'b1;
    tick();
    reset = 1'b0;

    look(100, 60);
    chk("rst_body", int'(enemyDrawReq), 1);
    chk("rst_id", int'(drawingRequestorId), 0);
    chk("rst_offX", int'(offsetX), 0);
    chk("rst_offY", int'(offsetY), 0);
    chk("rst_alive", int'(aliveCount), 2);
    chk("rst_kill", int'(killPulse), 0);
    look(100, 59);
    chk("rst_headsUp", int'(headsUpDrawReq), 1);
    chk("rst_headsUp_body", int'(enemyDrawReq), 0);

    repeat (210) frame();
    look(620, 120);
    chk("edge_body", int'(enemyDrawReq), 1);
    chk("edge_id", int'(drawingRequestorId), 1);
    chk("edge_offX", int'(offsetX), 0);
    look(630, 125);
    chk("edge_offX10", int'(offsetX), 10);
    frame();
    look(630, 125);
    chk("clamp_offX", int'(offsetX), 10);
    frame();
    look(630, 125);
    chk("flipped_offX", int'(offsetX), 12);

    repeat (23) frame();
    look(575, 70);
    chk("arb_body0_req", int'(enemyDrawReq), 1);
    chk("arb_body0_id", int'(drawingRequestorId), 0);
    chk("arb_body0_offX", int'(offsetX), 5);
    chk("arb_body0_hu", int'(headsUpDrawReq), 1);
    look(575, 125);
    chk("arb_body1_id", int'(drawingRequestorId), 1);
    chk("arb_body1_offY", int'(offsetY), 5);
    chk("arb_body1_hd", int'(headsDownDrawReq), 1);
    look(575, 150);
    chk("arb_hd_req", int'(enemyDrawReq), 0);
    chk("arb_hd_id", int'(drawingRequestorId), 0);

    changeDir = 1'b1;
    pixelX = 11'd575; pixelY = 11'd125;
    tick();
    changeDir = 1'b0;
    frame();
    look(580, 125);
    chk("flip_offX", int'(offsetX), 6);

    shoot(5);
    frame();
    chk("five_shots_no_kill", killSeen, 0);
    shoot(1);
    pause = 1'b1;
    frame();
    pause = 1'b0;
    chk("paused_no_kill", killSeen, 0);
    frame();
    chk("second_hit_no_kill", killSeen, 0);
    shoot(1);
    frame();
    chk("third_hit_kill", killSeen, 1);
    chk("alive_after_kill", int'(aliveCount), 1);
    look(mX[0] + 5, 65);
    chk("exploding_draw", int'(explodingDrawReq), 1);

    repeat (15) frame();
    look(mX[0] + 5, 65);
    chk("explode_last_frame", int'(explodingDrawReq), 1);
    frame();
    look(mX[0] + 5, 65);
    chk("respawn_hidden", int'(enemyDrawReq), 0);

    repeat (125) frame();
    look(100, 60);
    chk("respawn_hold", int'(enemyDrawReq), 0);
    spawnEnable = 1'b1;
    frame();
    look(100, 60);
    chk("respawn_body", int'(enemyDrawReq), 1);
    chk("respawn_offX", int'(offsetX), 0);
    chk("respawn_offY", int'(offsetY), 0);
    chk("respawn_alive", int'(aliveCount), 2);

    shoot(1);
    frame();
    shoot(1);
    frame();
    chk("hits_cleared", killSeen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
